// File: rtl/axil_arbiter_2to1.sv
// rtl/axil_arbiter_2to1.sv - round-robin 2:1 AXI4-Lite arbiter, one transaction outstanding
// Optional response timeout enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_arbiter_2to1 #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    // requester 0
    input  logic                i_in0_awvalid,
    output logic                o_in0_awready,
    input  logic [ADDR_W-1:0]   i_in0_awaddr,
    input  logic [2:0]          i_in0_awprot,
    input  logic                i_in0_wvalid,
    output logic                o_in0_wready,
    input  logic [DATA_W-1:0]   i_in0_wdata,
    input  logic [DATA_W/8-1:0] i_in0_wstrb,
    output logic                o_in0_bvalid,
    input  logic                i_in0_bready,
    output logic [1:0]          o_in0_bresp,
    input  logic                i_in0_arvalid,
    output logic                o_in0_arready,
    input  logic [ADDR_W-1:0]   i_in0_araddr,
    input  logic [2:0]          i_in0_arprot,
    output logic                o_in0_rvalid,
    input  logic                i_in0_rready,
    output logic [DATA_W-1:0]   o_in0_rdata,
    output logic [1:0]          o_in0_rresp,
    // requester 1
    input  logic                i_in1_awvalid,
    output logic                o_in1_awready,
    input  logic [ADDR_W-1:0]   i_in1_awaddr,
    input  logic [2:0]          i_in1_awprot,
    input  logic                i_in1_wvalid,
    output logic                o_in1_wready,
    input  logic [DATA_W-1:0]   i_in1_wdata,
    input  logic [DATA_W/8-1:0] i_in1_wstrb,
    output logic                o_in1_bvalid,
    input  logic                i_in1_bready,
    output logic [1:0]          o_in1_bresp,
    input  logic                i_in1_arvalid,
    output logic                o_in1_arready,
    input  logic [ADDR_W-1:0]   i_in1_araddr,
    input  logic [2:0]          i_in1_arprot,
    output logic                o_in1_rvalid,
    input  logic                i_in1_rready,
    output logic [DATA_W-1:0]   o_in1_rdata,
    output logic [1:0]          o_in1_rresp,
    // shared target
    output logic                o_out_awvalid,
    input  logic                i_out_awready,
    output logic [ADDR_W-1:0]   o_out_awaddr,
    output logic [2:0]          o_out_awprot,
    output logic                o_out_wvalid,
    input  logic                i_out_wready,
    output logic [DATA_W-1:0]   o_out_wdata,
    output logic [DATA_W/8-1:0] o_out_wstrb,
    input  logic                i_out_bvalid,
    output logic                o_out_bready,
    input  logic [1:0]          i_out_bresp,
    output logic                o_out_arvalid,
    input  logic                i_out_arready,
    output logic [ADDR_W-1:0]   o_out_araddr,
    output logic [2:0]          o_out_arprot,
    input  logic                i_out_rvalid,
    output logic                o_out_rready,
    input  logic [DATA_W-1:0]   i_out_rdata,
    input  logic [1:0]          i_out_rresp,
    output logic                grant,
    output logic                busy
);

    typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_RESP} state_t;

    state_t r_state;
    logic   r_grant, r_last, r_busy, r_aw_done, r_w_done;
    logic   w_req0, w_req1, w_pick, w_pick_aw;
    logic   w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;
    logic   w_aw_hs, w_w_hs, w_to, w_drain;
    logic   w_up_awready, w_up_wready, w_up_bvalid, w_up_arready, w_up_rvalid;

    assign w_req0    = i_in0_awvalid | i_in0_arvalid;
    assign w_req1    = i_in1_awvalid | i_in1_arvalid;
    assign w_pick    = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_pick_aw = w_pick ? i_in1_awvalid : i_in0_awvalid;

    assign w_g_awvalid = r_grant ? i_in1_awvalid : i_in0_awvalid;
    assign w_g_wvalid  = r_grant ? i_in1_wvalid  : i_in0_wvalid;
    assign w_g_bready  = r_grant ? i_in1_bready  : i_in0_bready;
    assign w_g_arvalid = r_grant ? i_in1_arvalid : i_in0_arvalid;
    assign w_g_rready  = r_grant ? i_in1_rready  : i_in0_rready;

    // Payloads always follow the current owner, valid or not.
    assign o_out_awaddr = r_grant ? i_in1_awaddr : i_in0_awaddr;
    assign o_out_awprot = r_grant ? i_in1_awprot : i_in0_awprot;
    assign o_out_wdata  = r_grant ? i_in1_wdata  : i_in0_wdata;
    assign o_out_wstrb  = r_grant ? i_in1_wstrb  : i_in0_wstrb;
    assign o_out_araddr = r_grant ? i_in1_araddr : i_in0_araddr;
    assign o_out_arprot = r_grant ? i_in1_arprot : i_in0_arprot;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_to, r_out_en;
    logic          w_rsp_state, w_rsp_valid;

    assign w_rsp_state = (r_state == S_WR_RESP) | (r_state == S_RD_RESP);
    assign w_rsp_valid = (r_state == S_WR_RESP) ? i_out_bvalid : i_out_rvalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_to     <= 1'b0;
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            if (!w_rsp_state) begin
                r_cnt <= '0;
                r_to  <= 1'b0;
            end else if (!r_to && !w_rsp_valid) begin
                if (r_cnt == TO_LAST) r_to  <= 1'b1;
                else                  r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_to    = r_to;
    // Late target responses are soaked up while nobody owns the bus.
    assign w_drain = r_out_en & (r_state == S_IDLE);
`else
    assign w_to    = 1'b0;
    assign w_drain = 1'b0;
`endif

    assign o_out_awvalid = (r_state == S_WR_ADDR) & w_g_awvalid & ~r_aw_done;
    assign o_out_wvalid  = (r_state == S_WR_ADDR) & w_g_wvalid  & ~r_w_done;
    assign o_out_bready  = ((r_state == S_WR_RESP) & ~w_to & w_g_bready) | w_drain;
    assign o_out_arvalid = (r_state == S_RD_ADDR) & w_g_arvalid;
    assign o_out_rready  = ((r_state == S_RD_RESP) & ~w_to & w_g_rready) | w_drain;

    assign w_aw_hs = o_out_awvalid & i_out_awready;
    assign w_w_hs  = o_out_wvalid  & i_out_wready;

    assign w_up_awready = (r_state == S_WR_ADDR) & i_out_awready & ~r_aw_done;
    assign w_up_wready  = (r_state == S_WR_ADDR) & i_out_wready  & ~r_w_done;
    assign w_up_bvalid  = (r_state == S_WR_RESP) & (w_to | i_out_bvalid);
    assign w_up_arready = (r_state == S_RD_ADDR) & i_out_arready;
    assign w_up_rvalid  = (r_state == S_RD_RESP) & (w_to | i_out_rvalid);

    assign o_in0_awready = ~r_grant & w_up_awready;
    assign o_in1_awready =  r_grant & w_up_awready;
    assign o_in0_wready  = ~r_grant & w_up_wready;
    assign o_in1_wready  =  r_grant & w_up_wready;
    assign o_in0_bvalid  = ~r_grant & w_up_bvalid;
    assign o_in1_bvalid  =  r_grant & w_up_bvalid;
    assign o_in0_arready = ~r_grant & w_up_arready;
    assign o_in1_arready =  r_grant & w_up_arready;
    assign o_in0_rvalid  = ~r_grant & w_up_rvalid;
    assign o_in1_rvalid  =  r_grant & w_up_rvalid;

    assign o_in0_bresp = w_to ? 2'b10 : i_out_bresp;
    assign o_in1_bresp = w_to ? 2'b10 : i_out_bresp;
    assign o_in0_rresp = w_to ? 2'b10 : i_out_rresp;
    assign o_in1_rresp = w_to ? 2'b10 : i_out_rresp;
    assign o_in0_rdata = w_to ? '0 : i_out_rdata;
    assign o_in1_rdata = w_to ? '0 : i_out_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_busy    <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant   <= w_pick;
                        r_last    <= w_pick;
                        r_busy    <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= w_pick_aw ? S_WR_ADDR : S_RD_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    // A handshake landing this cycle counts toward completion.
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_state <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (w_up_bvalid & w_g_bready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RD_ADDR: begin
                    if (o_out_arvalid & i_out_arready) r_state <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (w_up_rvalid & w_g_rready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// tb/tb_axil_arbiter_2to1.sv - directed bench for axil_arbiter_2to1 with a small RAM target
module tb_axil_arbiter_2to1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic [1:0]  m0_bresp, m0_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp, m1_rresp;

    logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
    logic [31:0] o_awaddr, o_wdata, o_araddr;
    logic [2:0]  o_awprot, o_arprot;
    logic [3:0]  o_wstrb;
    logic        t_bvalid, t_rvalid, t_stall_b;
    logic [31:0] t_rdata;
    logic        grant, busy;

    int n_chk  = 0;
    int n_fail = 0;

    axil_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_in0_awvalid(m0_awvalid), .o_in0_awready(m0_awready), .i_in0_awaddr(m0_awaddr),
        .i_in0_awprot(3'b000), .i_in0_wvalid(m0_wvalid), .o_in0_wready(m0_wready),
        .i_in0_wdata(m0_wdata), .i_in0_wstrb(m0_wstrb), .o_in0_bvalid(m0_bvalid),
        .i_in0_bready(m0_bready), .o_in0_bresp(m0_bresp), .i_in0_arvalid(m0_arvalid),
        .o_in0_arready(m0_arready), .i_in0_araddr(m0_araddr), .i_in0_arprot(3'b000),
        .o_in0_rvalid(m0_rvalid), .i_in0_rready(m0_rready), .o_in0_rdata(m0_rdata),
        .o_in0_rresp(m0_rresp),
        .i_in1_awvalid(m1_awvalid), .o_in1_awready(m1_awready), .i_in1_awaddr(m1_awaddr),
        .i_in1_awprot(3'b001), .i_in1_wvalid(m1_wvalid), .o_in1_wready(m1_wready),
        .i_in1_wdata(m1_wdata), .i_in1_wstrb(m1_wstrb), .o_in1_bvalid(m1_bvalid),
        .i_in1_bready(m1_bready), .o_in1_bresp(m1_bresp), .i_in1_arvalid(m1_arvalid),
        .o_in1_arready(m1_arready), .i_in1_araddr(m1_araddr), .i_in1_arprot(3'b001),
        .o_in1_rvalid(m1_rvalid), .i_in1_rready(m1_rready), .o_in1_rdata(m1_rdata),
        .o_in1_rresp(m1_rresp),
        .o_out_awvalid(o_awvalid), .i_out_awready(1'b1), .o_out_awaddr(o_awaddr),
        .o_out_awprot(o_awprot), .o_out_wvalid(o_wvalid), .i_out_wready(1'b1),
        .o_out_wdata(o_wdata), .o_out_wstrb(o_wstrb), .i_out_bvalid(t_bvalid),
        .o_out_bready(o_bready), .i_out_bresp(2'b00), .o_out_arvalid(o_arvalid),
        .i_out_arready(1'b1), .o_out_araddr(o_araddr), .o_out_arprot(o_arprot),
        .i_out_rvalid(t_rvalid), .o_out_rready(o_rready), .i_out_rdata(t_rdata),
        .i_out_rresp(2'b00),
        .grant(grant), .busy(busy)
    );

    // RAM target: always-ready address/data channels, optional B stall.
    logic [31:0] mem [16];
    logic [31:0] s_awaddr, s_wdata, s_a, s_d;
    logic        s_got_aw, s_got_w, s_bpend, s_aw_hs, s_w_hs;
    logic        s_loaded = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_bvalid <= 1'b0;
            t_rvalid <= 1'b0;
            t_rdata  <= '0;
            s_got_aw <= 1'b0;
            s_got_w  <= 1'b0;
            s_bpend  <= 1'b0;
            if (!s_loaded) begin
                for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
                s_loaded <= 1'b1;
            end
        end else begin
            s_aw_hs = o_awvalid;
            s_w_hs  = o_wvalid;
            s_a     = s_aw_hs ? o_awaddr : s_awaddr;
            s_d     = s_w_hs ? o_wdata : s_wdata;
            if (t_bvalid && o_bready) t_bvalid <= 1'b0;
            if (t_rvalid && o_rready) t_rvalid <= 1'b0;
            if (s_aw_hs) begin s_got_aw <= 1'b1; s_awaddr <= o_awaddr; end
            if (s_w_hs)  begin s_got_w  <= 1'b1; s_wdata  <= o_wdata;  end
            if ((s_got_aw || s_aw_hs) && (s_got_w || s_w_hs)) begin
                mem[s_a[5:2]] <= s_d;
                s_got_aw <= 1'b0;
                s_got_w  <= 1'b0;
                if (t_stall_b) s_bpend  <= 1'b1;
                else           t_bvalid <= 1'b1;
            end
            if (s_bpend && !t_stall_b) begin
                t_bvalid <= 1'b1;
                s_bpend  <= 1'b0;
            end
            if (o_arvalid) begin
                t_rvalid <= 1'b1;
                t_rdata  <= mem[o_araddr[5:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; t_stall_b = 1'b0;
        {m0_awvalid, m0_wvalid, m0_arvalid, m1_awvalid, m1_wvalid, m1_arvalid} = '0;
        {m0_awaddr, m0_wdata, m0_araddr, m1_awaddr, m1_wdata, m1_araddr} = '0;
        m0_wstrb = 4'hF; m1_wstrb = 4'hF;
        m0_bready = 1'b1; m0_rready = 1'b1; m1_bready = 1'b1; m1_rready = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_out_awvalid", o_awvalid, 0);
        chk("rst_out_bready", o_bready, 0);
        chk("rst_in0_awready", m0_awready, 0);
        tick(); tick();
        reset_n = 1'b1;
        #1 chk("rel_busy", busy, 0);

        // Read tie right after reset: in0 first, then in1
        tick(); m0_arvalid = 1; m0_araddr = 32'h0; m1_arvalid = 1; m1_araddr = 32'h4;
        #1 chk("tie_idle_arvalid", o_arvalid, 0);
        tick(); #1;
        chk("tie_grant0", grant, 0);
        chk("tie_out_arvalid", o_arvalid, 1);
        chk("tie_out_araddr0", o_araddr, 32'h0);
        chk("tie_in0_arready", m0_arready, 1);
        chk("tie_in1_arready", m1_arready, 0);
        chk("tie_busy", busy, 1);
        tick(); m0_arvalid = 0; #1;
        chk("tie_in0_rvalid", m0_rvalid, 1);
        chk("tie_in0_rdata", m0_rdata, 32'hA000_0000);
        chk("tie_in1_rvalid", m1_rvalid, 0);
        tick(); #1 chk("tie_idle_gap", busy, 0);
        tick(); #1;
        chk("tie_grant1", grant, 1);
        chk("tie_out_araddr1", o_araddr, 32'h4);
        chk("tie_out_arprot1", o_arprot, 3'b001);
        tick(); m1_arvalid = 0; #1;
        chk("tie_in1_rvalid", m1_rvalid, 1);
        chk("tie_in1_rdata", m1_rdata, 32'hA000_0001);
        tick(); #1 chk("tie_done", busy, 0);

        // Single write from in0
        tick(); m0_awvalid = 1; m0_awaddr = 32'h10; m0_wvalid = 1; m0_wdata = 32'hDEAD_BEEF;
        #1 chk("wr_idle_awvalid", o_awvalid, 0);
        tick(); #1;
        chk("wr_out_awvalid", o_awvalid, 1);
        chk("wr_out_awaddr", o_awaddr, 32'h10);
        chk("wr_out_wvalid", o_wvalid, 1);
        chk("wr_out_wdata", o_wdata, 32'hDEAD_BEEF);
        chk("wr_out_wstrb", o_wstrb, 4'hF);
        chk("wr_grant", grant, 0);
        chk("wr_in1_awready", m1_awready, 0);
        tick(); m0_awvalid = 0; m0_wvalid = 0; #1;
        chk("wr_in0_bvalid", m0_bvalid, 1);
        chk("wr_in0_bresp", m0_bresp, 2'b00);
        chk("wr_busy_resp", busy, 1);
        tick(); #1 chk("wr_busy_fall", busy, 0);

        // Split write from in1: W arrives three cycles after AW
        tick(); m1_awvalid = 1; m1_awaddr = 32'h8; m1_wdata = 32'hCAFE_F00D;
        tick(); #1;
        chk("sp_out_awvalid", o_awvalid, 1);
        chk("sp_out_wvalid0", o_wvalid, 0);
        chk("sp_grant", grant, 1);
        tick(); m1_awvalid = 0; #1;
        chk("sp_aw_done", o_awvalid, 0);
        chk("sp_out_wvalid1", o_wvalid, 0);
        chk("sp_no_b1", m1_bvalid, 0);
        tick(); m1_wvalid = 1; #1;
        chk("sp_out_wvalid", o_wvalid, 1);
        chk("sp_out_wdata", o_wdata, 32'hCAFE_F00D);
        chk("sp_no_b2", m1_bvalid, 0);
        tick(); m1_wvalid = 0; #1;
        chk("sp_in1_bvalid", m1_bvalid, 1);
        tick(); #1 chk("sp_done", busy, 0);

        // Write and read together from in0: write first, read after an IDLE cycle
        tick(); m0_awvalid = 1; m0_awaddr = 32'h14; m0_wvalid = 1; m0_wdata = 32'h1234_5678;
        m0_arvalid = 1; m0_araddr = 32'h14;
        tick(); #1;
        chk("wr_rd_awvalid", o_awvalid, 1);
        chk("wr_rd_no_ar", o_arvalid, 0);
        tick(); m0_awvalid = 0; m0_wvalid = 0; #1;
        chk("wr_rd_bvalid", m0_bvalid, 1);
        chk("wr_rd_arready", m0_arready, 0);
        tick(); #1;
        chk("wr_rd_idle", busy, 0);
        chk("wr_rd_idle_ar", o_arvalid, 0);
        tick(); #1 chk("wr_rd_arvalid", o_arvalid, 1);
        tick(); m0_arvalid = 0; #1;
        chk("wr_rd_rvalid", m0_rvalid, 1);
        chk("wr_rd_rdata", m0_rdata, 32'h1234_5678);
        tick(); #1;

        // Reset while in1 holds a read response
        m1_rready = 0; m1_arvalid = 1; m1_araddr = 32'h10;
        tick(); #1 chk("mr_grant1", grant, 1);
        tick(); m1_arvalid = 0; #1;
        chk("mr_rvalid", m1_rvalid, 1);
        chk("mr_rdata", m1_rdata, 32'hDEAD_BEEF);
        tick(); #1;
        reset_n = 0; #1;
        chk("mr_busy", busy, 0);
        chk("mr_rvalid_drop", m1_rvalid, 0);
        chk("mr_grant_rst", grant, 0);
        chk("mr_out_rready", o_rready, 0);
        tick();
        reset_n = 1; m1_rready = 1;
        m0_arvalid = 1; m0_araddr = 32'h8; m1_arvalid = 1; m1_araddr = 32'hC;
        tick(); #1;
        chk("mr_tie_grant0", grant, 0);
        chk("mr_tie_araddr", o_araddr, 32'h8);
        tick(); m0_arvalid = 0; #1 chk("mr_rdata0", m0_rdata, 32'hCAFE_F00D);
        tick(); #1;
        tick(); #1 chk("mr_grant1b", grant, 1);
        tick(); m1_arvalid = 0; #1 chk("mr_rdata1", m1_rdata, 32'hA000_0003);
        tick(); #1 chk("mr_done", busy, 0);

`ifdef AXIL_ARB_TIMEOUT_EN
        // Stalled B channel: SLVERR after 16 response cycles, late B drained in IDLE
        t_stall_b = 1;
        tick(); m0_awvalid = 1; m0_awaddr = 32'h18; m0_wvalid = 1; m0_wdata = 32'h55AA_55AA;
        tick();
        tick(); m0_awvalid = 0; m0_wvalid = 0; #1 chk("to_c0", m0_bvalid, 0);
        for (int k = 1; k < 16; k++) begin
            tick(); #1 chk("to_wait", m0_bvalid, 0);
        end
        tick(); #1;
        chk("to_bvalid", m0_bvalid, 1);
        chk("to_bresp", m0_bresp, 2'b10);
        chk("to_out_bready", o_bready, 0);
        tick(); t_stall_b = 0; #1;
        chk("to_idle", busy, 0);
        chk("to_drain_ready", o_bready, 1);
        tick(); #1;
        chk("to_drain_bready", o_bready, 1);
        chk("to_drain_hidden", m0_bvalid, 0);
        tick(); m0_awvalid = 1; m0_awaddr = 32'h1C; m0_wvalid = 1; m0_wdata = 32'h0BAD_CAFE;
        tick();
        tick(); m0_awvalid = 0; m0_wvalid = 0; #1;
        chk("to_next_bvalid", m0_bvalid, 1);
        chk("to_next_bresp", m0_bresp, 2'b00);
        tick(); #1 chk("to_next_done", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
